// File: rtl/fp_dot_acc_pkg.sv
// Shared types and constants for the floating-point dot-product accumulator.
package fp_dot_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int FP_W     = SIGN_W + EXP_W + MANT_W;
  localparam int EXP_BIAS = 127;

  // Working mantissa: hidden bit + fraction + guard, round and sticky bits.
  localparam int EXT_W = MANT_W + 1 + 3;

  localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_MAX_POS = 32'h7F7F_FFFF;
  localparam logic [FP_W-1:0] FP_MAX_NEG = 32'hFF7F_FFFF;

endpackage

// File: rtl/fp_dot_acc_add_core.sv
// Combinational IEEE-754 single adder, truncating, with zero/denormal flush
// and saturation to max finite magnitude on exponent overflow.
module fp_add_core
  import fp_dot_acc_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic [EXP_W-1:0]  ea, eb, big_e, small_e, diff;
  logic [MANT_W:0]   ma, mb, big_m, small_m;
  logic              swap, big_s, small_s, sticky;
  logic [EXT_W-1:0]  big_x, small_x, small_al;
  logic [EXT_W:0]    raw, norm;
  logic [4:0]        msb, sh;
  logic signed [9:0] exp_r;

  assign ea   = a[FP_W-2 -: EXP_W];
  assign eb   = b[FP_W-2 -: EXP_W];
  assign ma   = (ea == '0) ? '0 : {1'b1, a[MANT_W-1:0]};
  assign mb   = (eb == '0) ? '0 : {1'b1, b[MANT_W-1:0]};
  assign swap = {eb, mb} > {ea, ma};

  always_comb begin
    big_s   = swap ? b[FP_W-1] : a[FP_W-1];
    small_s = swap ? a[FP_W-1] : b[FP_W-1];
    big_e   = swap ? eb : ea;
    small_e = swap ? ea : eb;
    big_m   = swap ? mb : ma;
    small_m = swap ? ma : mb;
    diff    = big_e - small_e;
    big_x   = {big_m, 3'b000};
    small_x = {small_m, 3'b000};
    if (diff >= 8'd27) begin
      small_al = '0;
      sticky   = |small_x;
    end else begin
      small_al = small_x >> diff;
      sticky   = |(small_x & ((27'd1 << diff) - 27'd1));
    end
    // Folding lost bits into the LSB keeps truncation exact when subtracting.
    small_al[0] = small_al[0] | sticky;
    if (big_s == small_s) raw = {1'b0, big_x} + {1'b0, small_al};
    else                  raw = {1'b0, big_x} - {1'b0, small_al};
    msb = '0;
    for (int i = 0; i <= EXT_W; i++) begin
      if (raw[i]) msb = 5'(i);
    end
    sh    = 5'd27 - msb;
    norm  = raw << sh;
    exp_r = $signed({2'b00, big_e}) + 10'sd1 - $signed({5'b00000, sh});
    if (raw == '0 || exp_r <= 10'sd0) sum = FP_ZERO;
    else if (exp_r >= 10'sd255)        sum = big_s ? FP_MAX_NEG : FP_MAX_POS;
    else                               sum = {big_s, exp_r[EXP_W-1:0], norm[EXT_W-1 -: MANT_W]};
  end

endmodule

// File: rtl/fp_dot_acc.sv
// Dot-product accumulator: sums len FP products onto a bias, one term per clock,
// then holds the (optionally ReLU-clamped) result until the consumer takes it.
module fp_dot_acc
  import fp_dot_acc_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [FP_W-1:0]  bias,
  input  logic             relu_en,
  input  logic [FP_W-1:0]  prod,
  input  logic             prod_vld,
  output logic             prod_rdy,
  output logic [FP_W-1:0]  result,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [FP_W-1:0]  acc_q, acc_d, sum;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             relu_q, relu_d;
  logic             accept;

  fp_add_core u_add (
    .a   (acc_q),
    .b   (prod),
    .sum (sum)
  );

  assign prod_rdy = (state_q == ACCUM);
  assign res_vld  = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign accept   = prod_vld && prod_rdy;
  assign result   = !res_vld ? FP_ZERO :
                    (relu_q && acc_q[FP_W-1]) ? FP_ZERO : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    relu_d  = relu_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          rem_d   = len;
          relu_d  = relu_en;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        // remaining is at least 1 here, so the decrement cannot wrap.
        if (accept) begin
          acc_d = sum;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= FP_ZERO;
      rem_q   <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      relu_q  <= relu_d;
    end
  end

endmodule

// File: tb/tb_fp_dot_acc.sv
// Randomised scoreboard bench for fp_dot_acc with an exact-arithmetic reference adder.
module tb_fp_dot_acc;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [31:0]      bias;
  logic             relu_en;
  logic [31:0]      prod;
  logic             prod_vld;
  logic             prod_rdy;
  logic [31:0]      result;
  logic             res_vld;
  logic             res_rdy;
  logic             busy;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          hold_rdy = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_res = '0;
  logic [31:0] exp_q[$];
  logic [31:0] terms_a[16];

  fp_dot_acc #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
    .relu_en(relu_en), .prod(prod), .prod_vld(prod_vld), .prod_rdy(prod_rdy),
    .result(result), .res_vld(res_vld), .res_rdy(res_rdy), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact model: every operand is an integer multiple of 2^-149, so sum exactly then truncate.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic [279:0] mx, my, m, t;
    logic s;
    int p, e;
    mx = (x[30:23] == 8'd0) ? '0 : (280'({1'b1, x[22:0]}) << (int'(x[30:23]) - 1));
    my = (y[30:23] == 8'd0) ? '0 : (280'({1'b1, y[22:0]}) << (int'(y[30:23]) - 1));
    if (x[31] == y[31]) begin m = mx + my; s = x[31]; end
    else if (mx >= my)  begin m = mx - my; s = x[31]; end
    else                begin m = my - mx; s = y[31]; end
    if (m == '0) return 32'h0000_0000;
    p = 0;
    for (int i = 0; i < 280; i++) if (m[i]) p = i;
    e = p - 22;
    if (e < 1) return 32'h0000_0000;
    if (e > 254) return s ? 32'hFF7F_FFFF : 32'h7F7F_FFFF;
    t = m >> (e - 1);
    return {s, 8'(e), t[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp(input logic [31:0] acc);
    int r;
    logic sg;
    r  = int'($urandom_range(0, 15));
    sg = 1'($urandom_range(0, 1));
    if (r == 0) return {sg, 8'h00, 23'($urandom)};
    if (r == 1) return {sg, 8'($urandom_range(250, 254)), 23'($urandom)};
    if (r == 2 && acc[30:23] != 8'd0) return {~acc[31], acc[30:0]};
    if (r == 3) return {sg, 8'($urandom_range(1, 254)), 23'($urandom)};
    return {sg, 8'($urandom_range(118, 136)), 23'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Starts a job with terms_a[0..n-1], feeds it, and returns once res_vld is seen.
  task automatic run_job(input int n, input logic [31:0] bias_v, input logic relu_v,
                         input int bub, input bit noise, input logic [31:0] exp_v,
                         output int lat, output bit rdy_seen);
    int b, idx, first, start_cyc;
    b = 0;
    while (busy && b < 300) begin @(negedge clk); b++; end
    if (busy) chk("idle_wait_timeout", 32'(busy), 32'd0);
    start = 1'b1; len = LEN_W'(n); bias = bias_v; relu_en = relu_v;
    start_cyc = cyc;
    exp_q.push_back(exp_v);
    @(negedge clk);
    start = 1'b0; len = LEN_W'($urandom); bias = $urandom; relu_en = 1'($urandom);
    idx = 0; first = -1; b = 0; rdy_seen = 1'b0;
    while (idx < n && b < 500) begin
      prod_vld = (int'($urandom_range(0, 99)) >= bub);
      prod     = prod_vld ? terms_a[idx] : $urandom;
      start    = noise && ($urandom_range(0, 5) == 0);
      len      = LEN_W'($urandom);
      if (prod_vld && prod_rdy) begin
        if (first < 0) first = cyc;
        idx++;
      end
      @(negedge clk);
      b++;
    end
    prod_vld = 1'b0; start = 1'b0;
    if (idx < n) chk("feed_timeout", 32'(idx), 32'(n));
    b = 0;
    while (!res_vld && b < 50) begin
      if (prod_rdy) rdy_seen = 1'b1;
      start = noise && ($urandom_range(0, 1) == 0);
      @(negedge clk);
      b++;
    end
    start = 1'b0;
    if (prod_rdy) rdy_seen = 1'b1;
    if (!res_vld) chk("res_vld_timeout", 32'(res_vld), 32'd1);
    lat = cyc - ((n > 0) ? first : start_cyc);
  endtask

  task automatic finish_job(input bit noise);
    int b;
    b = 0;
    while (busy && b < 300) begin
      start = noise && ($urandom_range(0, 1) == 0);
      @(negedge clk);
      b++;
    end
    start = 1'b0;
    if (busy) chk("handoff_timeout", 32'(busy), 32'd0);
  endtask

  task automatic directed(input int n, input logic [31:0] bias_v, input logic relu_v,
                          input logic [31:0] exp_v);
    int lat;
    bit rs;
    run_job(n, bias_v, relu_v, 0, 1'b0, exp_v, lat, rs);
    finish_job(1'b0);
  endtask

  // Consumer: random ready, or forced low for the stall test.
  initial begin
    res_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1 res_rdy = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: checks hold stability while stalled and pops the scoreboard on each handoff.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!res_vld || result !== prev_res) begin
          failures++;
          $display("FAIL hold_stable: got vld=%0b res=%h expected vld=1 res=%h", res_vld, result, prev_res);
        end
      end
      if (res_vld && res_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: got %h expected none", result);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (result !== e) begin
            failures++;
            $display("FAIL result: got %h expected %h", result, e);
          end else begin
            $display("result ok %h", result);
          end
        end
      end
      hold_prev <= res_vld && !res_rdy;
      prev_res  <= result;
    end
  end

  initial begin
    int lat, n, b;
    bit rs, noise, relu_v;
    logic [31:0] acc, bias_v;
    rst_n = 1'b0; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
    prod = '0; prod_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {prod_rdy, res_vld, busy}, 3'b000);
    chk("reset_result", result, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back 1+2+3 with latency check.
    terms_a[0] = 32'h3F80_0000; terms_a[1] = 32'h4000_0000; terms_a[2] = 32'h4040_0000;
    run_job(3, 32'h0, 1'b0, 0, 1'b0, 32'h40C0_0000, lat, rs);
    chk("latency_3_terms", 32'(lat), 32'd3);
    finish_job(1'b0);

    terms_a[0] = 32'hC000_0000;
    directed(1, 32'h3F80_0000, 1'b0, 32'hBF80_0000);
    directed(1, 32'h3F80_0000, 1'b1, 32'h0000_0000);

    run_job(0, 32'h4120_0000, 1'b0, 0, 1'b0, 32'h4120_0000, lat, rs);
    chk("len0_latency", 32'(lat), 32'd1);
    chk("len0_prod_rdy_never", 32'(rs), 32'd0);
    finish_job(1'b0);

    // Bubbles on the product side and a stalled consumer.
    hold_rdy = 1'b1;
    terms_a[0] = 32'h4080_0000; terms_a[1] = 32'hBF00_0000;
    run_job(2, 32'h3F80_0000, 1'b0, 60, 1'b0, 32'h4090_0000, lat, rs);
    repeat (5) @(negedge clk);
    chk("stall_vld_held", 32'(res_vld), 32'd1);
    hold_rdy = 1'b0;
    finish_job(1'b0);

    // Spurious starts during ACCUM and DONE.
    for (int i = 0; i < 4; i++) terms_a[i] = 32'h3F80_0000;
    run_job(4, 32'h0, 1'b0, 30, 1'b1, 32'h4080_0000, lat, rs);
    finish_job(1'b1);

    // Boundary arithmetic: saturation, cancellation, denormals, truncation.
    terms_a[0] = 32'h7F7F_FFFF; directed(1, 32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF);
    terms_a[0] = 32'hFF00_0000; directed(1, 32'hFF7F_FFFF, 1'b0, 32'hFF7F_FFFF);
    terms_a[0] = 32'hC049_0FDB; directed(1, 32'h4049_0FDB, 1'b0, 32'h0000_0000);
    terms_a[0] = 32'h3F80_0000; directed(1, 32'h0000_0001, 1'b0, 32'h3F80_0000);
    terms_a[0] = 32'h8080_0000; directed(1, 32'h0080_0001, 1'b0, 32'h0000_0000);
    terms_a[0] = 32'h33FF_FFFF; directed(1, 32'h3F80_0000, 1'b0, 32'h3F80_0000);
    terms_a[0] = 32'hB300_0001; directed(1, 32'h3F80_0000, 1'b0, 32'h3F7F_FFFF);

    // Reset in the middle of accumulation, then a clean job.
    b = 0;
    while (busy && b < 300) begin @(negedge clk); b++; end
    start = 1'b1; len = LEN_W'(4); bias = 32'h0;
    @(negedge clk);
    start = 1'b0; prod_vld = 1'b1; prod = 32'h3F80_0000;
    @(negedge clk);
    prod_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {prod_rdy, res_vld, busy}, 3'b000);
    chk("midreset_result", result, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    terms_a[0] = 32'h3F80_0000;
    directed(1, 32'h0, 1'b0, 32'h3F80_0000);

    // Random jobs against the exact reference.
    for (int j = 0; j < 40; j++) begin
      n      = int'($urandom_range(0, 12));
      bias_v = rand_fp(32'h0);
      relu_v = 1'($urandom_range(0, 1));
      noise  = 1'($urandom_range(0, 1));
      acc    = bias_v;
      for (int i = 0; i < n; i++) begin
        terms_a[i] = rand_fp(acc);
        acc = ref_add(acc, terms_a[i]);
      end
      if (relu_v && acc[31]) acc = 32'h0;
      run_job(n, bias_v, relu_v, int'($urandom_range(0, 50)), noise, acc, lat, rs);
      finish_job(noise);
    end

    b = 0;
    while (exp_q.size() != 0 && b < 100) begin @(negedge clk); b++; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
